// File: rtl/ocl_tile_slave_if.sv
// OCL AXI-lite-style bus between the arbiter (master) and a tile slave.
interface ocl_tile_slave_if;
  logic        ocl_awvalid;
  logic        ocl_awready;
  logic [31:0] ocl_awaddr;
  logic        ocl_wvalid;
  logic        ocl_wready;
  logic [31:0] ocl_wdata;
  logic        ocl_bvalid;
  logic        ocl_bready;
  logic        ocl_arvalid;
  logic        ocl_arready;
  logic [31:0] ocl_araddr;
  logic        ocl_rvalid;
  logic        ocl_rready;
  logic [31:0] ocl_rdata;

  modport master (
    output ocl_awvalid, ocl_awaddr, ocl_wvalid, ocl_wdata, ocl_bready,
           ocl_arvalid, ocl_araddr, ocl_rready,
    input  ocl_awready, ocl_wready, ocl_bvalid, ocl_arready, ocl_rvalid, ocl_rdata
  );

  modport slave (
    input  ocl_awvalid, ocl_awaddr, ocl_wvalid, ocl_wdata, ocl_bready,
           ocl_arvalid, ocl_araddr, ocl_rready,
    output ocl_awready, ocl_wready, ocl_bvalid, ocl_arready, ocl_rvalid, ocl_rdata
  );
endinterface

// File: rtl/ocl_tile_slave.sv
// Tile-side OCL slave: bridges one OCL transaction at a time onto the tile
// register strobe bus, with a read timeout that answers 32'hDEADBEEF.
module ocl_tile_slave #(
  parameter int N_COMP  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  ocl_tile_slave_if.slave        ocl,
  output logic                   reg_wvalid,
  output logic [15:0]            reg_waddr,
  output logic [31:0]            reg_wdata,
  output logic                   reg_rvalid,
  output logic [15:0]            reg_raddr,
  input  logic                   reg_rdata_valid,
  input  logic [31:0]            reg_rdata,
  output logic [15:0]            timeout_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT_W, DO_W, RESP_B, DO_R, WAIT_R, RESP_R
  } state_t;

  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  state_t      state, state_nxt;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [15:0] cnt_q;
  logic [15:0] tcount_q;
  logic        comp_ok;
  logic        cnt_last;

  assign comp_ok  = 32'(addr_q[15:8]) < 32'(N_COMP);
  assign cnt_last = cnt_q == 16'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ocl.ocl_awvalid)      state_nxt = WAIT_W;
        else if (ocl.ocl_arvalid) state_nxt = DO_R;
      end
      WAIT_W: if (ocl.ocl_wvalid) state_nxt = DO_W;
      DO_W:   state_nxt = RESP_B;
      RESP_B: if (ocl.ocl_bready) state_nxt = IDLE;
      DO_R:   state_nxt = comp_ok ? WAIT_R : RESP_R;
      WAIT_R: if (reg_rdata_valid || cnt_last) state_nxt = RESP_R;
      RESP_R: if (ocl.ocl_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      tcount_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ocl.ocl_awvalid)      addr_q <= ocl.ocl_awaddr[15:0];
          else if (ocl.ocl_arvalid) addr_q <= ocl.ocl_araddr[15:0];
        end
        WAIT_W: if (ocl.ocl_wvalid) wdata_q <= ocl.ocl_wdata;
        DO_R: begin
          if (comp_ok) cnt_q   <= '0;
          else         rdata_q <= BAD_DATA;
        end
        WAIT_R: begin
          // returned data beats a timeout landing in the same cycle
          if (reg_rdata_valid) begin
            rdata_q <= reg_rdata;
          end else if (cnt_last) begin
            rdata_q <= BAD_DATA;
            if (tcount_q != '1) tcount_q <= tcount_q + 16'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // strobes are masked by rst so a reset landing in DO_W/DO_R issues nothing
  always_comb begin
    ocl.ocl_awready = state == IDLE;
    ocl.ocl_arready = (state == IDLE) && !ocl.ocl_awvalid;
    ocl.ocl_wready  = state == WAIT_W;
    ocl.ocl_bvalid  = state == RESP_B;
    ocl.ocl_rvalid  = state == RESP_R;
    ocl.ocl_rdata   = rdata_q;
    reg_wvalid      = (state == DO_W) && comp_ok && !rst;
    reg_rvalid      = (state == DO_R) && comp_ok && !rst;
    reg_waddr       = addr_q;
    reg_wdata       = wdata_q;
    reg_raddr       = addr_q;
    timeout_count   = tcount_q;
  end

endmodule

// File: doc/ocl_tile_slave.md
OCL_TILE_SLAVE -- requirements
Module: ocl_tile_slave

Interface
REQ-001 SHALL have parameter N_COMP, default 16: number of register components in the tile; valid component IDs are 0..N_COMP-1.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum number of WAIT_R cycles before a read is abandoned.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports ocl_awvalid in 1, ocl_awready out 1, ocl_awaddr in 32: write-address channel from the OCL arbiter.
REQ-006 SHALL have ports ocl_wvalid in 1, ocl_wready out 1, ocl_wdata in 32: write-data channel.
REQ-007 SHALL have ports ocl_bvalid out 1, ocl_bready in 1: write-response channel.
REQ-008 SHALL have ports ocl_arvalid in 1, ocl_arready out 1, ocl_araddr in 32: read-address channel.
REQ-009 SHALL have ports ocl_rvalid out 1, ocl_rready in 1, ocl_rdata out 32: read-data channel.
REQ-010 SHALL have ports reg_wvalid out 1, reg_waddr out 16, reg_wdata out 32: tile register write strobe; reg_waddr[15:8] is the component, reg_waddr[7:0] is the offset.
REQ-011 SHALL have ports reg_rvalid out 1, reg_raddr out 16: tile register read request, with the same address format.
REQ-012 SHALL have ports reg_rdata_valid in 1, reg_rdata in 32: read return from the components.
REQ-013 SHALL have port timeout_count, out, 16: number of reads that timed out; saturates at 16'hFFFF.

Function
REQ-014 SHALL use the states IDLE, WAIT_W, DO_W, RESP_B, DO_R, WAIT_R and RESP_R.
REQ-015 SHALL drive ocl_awready=(state==IDLE) and ocl_arready=(state==IDLE)&!ocl_awvalid; a write wins over a simultaneous read, and the read stays pending.
REQ-016 SHALL behave as follows in IDLE:
- on ocl_awvalid: latch ocl_awaddr[15:0] and go to WAIT_W;
- otherwise, on ocl_arvalid: latch ocl_araddr[15:0] and go to DO_R;
- address bits [31:16] (the tile field) are ignored.
REQ-017 SHALL drive ocl_wready=(state==WAIT_W), and on ocl_wvalid latch ocl_wdata and go to DO_W.
REQ-018 SHALL in DO_W assert reg_wvalid for exactly one cycle, with the latched address and data, only if the component ID < N_COMP; an invalid component drops the write silently; next state is RESP_B.
REQ-019 SHALL in RESP_B hold ocl_bvalid=1 until ocl_bready is sampled high, then go to IDLE; response latency from W acceptance to bvalid is 2 cycles.
REQ-020 SHALL in DO_R:
- if the component is valid: assert reg_rvalid for one cycle, clear the timeout counter, and go to WAIT_R;
- if the component is invalid: load 32'hDEADBEEF into the read-data register and go to RESP_R.
REQ-021 SHALL in WAIT_R:
- on reg_rdata_valid: capture reg_rdata and go to RESP_R;
- otherwise increment the counter; when the counter == TIMEOUT-1 without valid data, load 32'hDEADBEEF, increment timeout_count (saturating), and go to RESP_R.
REQ-022 SHALL give reg_rdata_valid priority over timeout in the same cycle.
REQ-023 SHALL ignore reg_rdata_valid outside WAIT_R.
REQ-024 SHALL in RESP_R hold ocl_rvalid=1 with ocl_rdata stable until ocl_rready is sampled high, then go to IDLE.
REQ-025 SHALL keep reg_waddr, reg_wdata and reg_raddr equal to the latched registers; they are don't-care while the strobes are low.
REQ-026 SHALL have exactly one transaction outstanding at any time; no channel handshake SHALL combinationally depend on an input of the same channel.

Reset
REQ-027 SHALL on rst drive state to IDLE; the counter, timeout_count, ocl_rdata and all latched address/data registers to 0; and every valid output to 0 on the following cycle.
REQ-028 SHALL on rst mid-transaction abandon the transaction without issuing a response, and SHALL not issue a reg strobe in the reset cycle.

Verification
REQ-029 SHALL cover a write: AW 0x0003_0210 then W 0x1234_5678 -> reg_wvalid one cycle with reg_waddr 0x0210 and reg_wdata 0x1234_5678; bvalid 2 cycles after W; held until bready.
REQ-030 SHALL cover a read: AR 0x0000_0504 with reg_rdata_valid 3 cycles after reg_rvalid, data 0xCAFE_0001 -> rvalid with rdata 0xCAFE_0001, held while rready=0 for 5 cycles.
REQ-031 SHALL cover a timeout: AR to component 2 with no reg_rdata_valid -> rdata 0xDEADBEEF after TIMEOUT cycles in WAIT_R; timeout_count 1.
REQ-032 SHALL cover an invalid component: write to component 0x20 -> no reg_wvalid but bvalid; read from component 0x20 -> no reg_rvalid, rdata 0xDEADBEEF, timeout_count unchanged.
REQ-033 SHALL cover a collision: awvalid and arvalid in the same IDLE cycle -> write completes first, then the read is accepted.
REQ-034 SHALL cover reset mid-read: rst asserted in WAIT_R -> no rvalid and state IDLE; a later reg_rdata_valid is ignored.
